// File: rtl/vga_pkg.sv
// Shared timing defaults and pixel types for the NPC VGA display path.
package vga_pkg;

    localparam int unsigned DEF_H_ACT   = 640;
    localparam int unsigned DEF_H_FP    = 16;
    localparam int unsigned DEF_H_SYNC  = 96;
    localparam int unsigned DEF_H_BP    = 48;
    localparam int unsigned DEF_V_ACT   = 480;
    localparam int unsigned DEF_V_FP    = 10;
    localparam int unsigned DEF_V_SYNC  = 2;
    localparam int unsigned DEF_V_BP    = 33;
    localparam int unsigned DEF_CHAR_W  = 9;
    localparam int unsigned DEF_CHAR_H  = 16;
    localparam int unsigned DEF_ROM_LAT = 1;
    localparam int unsigned ROM_LAT_MAX = 3;

    localparam int unsigned COLOR_W = 24;
    localparam int unsigned CNT_W   = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline; DEPTH of 0 is a straight wire.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = pclk ^ reset;
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge pclk) begin
            if (!reset) begin
                for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= din;
                for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_text_timing.sv
// Programmable VGA raster generator with text/graphics colour path.
// Optional blinking text cursor is enabled with the VGA_CURSOR_EN macro.
module vga_text_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACT   = DEF_H_ACT,
    parameter int unsigned H_FP    = DEF_H_FP,
    parameter int unsigned H_SYNC  = DEF_H_SYNC,
    parameter int unsigned H_BP    = DEF_H_BP,
    parameter int unsigned V_ACT   = DEF_V_ACT,
    parameter int unsigned V_FP    = DEF_V_FP,
    parameter int unsigned V_SYNC  = DEF_V_SYNC,
    parameter int unsigned V_BP    = DEF_V_BP,
    parameter int unsigned CHAR_W  = DEF_CHAR_W,
    parameter int unsigned CHAR_H  = DEF_CHAR_H,
    parameter int unsigned ROM_LAT = DEF_ROM_LAT
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               text_mode,
    input  logic [COLOR_W-1:0] fg_color,
    input  logic [COLOR_W-1:0] bg_color,
    input  logic               rom_data,
    input  logic [COLOR_W-1:0] pix_data,
`ifdef VGA_CURSOR_EN
    input  logic [6:0]         cursor_col,
    input  logic [4:0]         cursor_row,
`endif
    output logic [9:0]         h_addr,
    output logic [9:0]         v_addr,
    output logic [6:0]         char_col,
    output logic [4:0]         char_row,
    output logic [3:0]         cell_x,
    output logic [3:0]         cell_y,
    output logic               hsync,
    output logic               vsync,
    output logic               valid,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               frame_start,
    output logic               line_start,
    output logic [7:0]         frame_cnt
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t H_START  = cnt_t'(H_SYNC + H_BP);
    localparam cnt_t H_END    = cnt_t'(H_SYNC + H_BP + H_ACT);
    localparam cnt_t H_SYNC_E = cnt_t'(H_SYNC);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t V_START  = cnt_t'(V_SYNC + V_BP);
    localparam cnt_t V_END    = cnt_t'(V_SYNC + V_BP + V_ACT);
    localparam cnt_t V_SYNC_E = cnt_t'(V_SYNC);

    localparam logic [3:0] CX_LAST = 4'(CHAR_W - 1);
    localparam logic [3:0] CY_LAST = 4'(CHAR_H - 1);

    // Memories slower than ROM_LAT_MAX are outside the supported range.
    localparam int unsigned LAT    = (ROM_LAT > ROM_LAT_MAX) ? ROM_LAT_MAX : ROM_LAT;
    localparam int unsigned PIPE_W = 7;

    cnt_t       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic       h_wrap, v_wrap, h_act, v_act, act, h_first, v_first, frame_top;
    logic [7:0] frame_cnt_q;
    logic       mode_q;

    cnt_t       h_addr_q, v_addr_q;
    logic [3:0] cx_q, cy_q;
    logic [6:0] col_q;
    logic [4:0] row_q;
    logic       act_q, hs_q, vs_q, fs_q, ls_q;
    logic       hit;

    logic [PIPE_W-1:0] pipe_in, pipe_out;
    logic              d_act, d_hs, d_vs, d_fs, d_ls, d_mode, d_hit;

    rgb_t rgb_q;
    logic valid_q, hsync_q, vsync_q, fstart_q, lstart_q;

    always_comb begin
        h_wrap    = (h_cnt_q == H_LAST);
        v_wrap    = (v_cnt_q == V_LAST);
        h_cnt_d   = h_wrap ? '0 : h_cnt_q + cnt_t'(1);
        v_cnt_d   = v_cnt_q;
        if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + cnt_t'(1);
        h_act     = (h_cnt_q >= H_START) && (h_cnt_q < H_END);
        v_act     = (v_cnt_q >= V_START) && (v_cnt_q < V_END);
        act       = h_act && v_act;
        h_first   = (h_cnt_q == H_START);
        v_first   = (v_cnt_q == V_START);
        frame_top = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Raster counters, frame counter and per-frame mode latch.
    always_ff @(posedge pclk) begin
        if (!reset) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            mode_q      <= 1'b1;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            if (h_wrap && v_wrap) frame_cnt_q <= frame_cnt_q + 8'd1;
            if (frame_top) mode_q <= text_mode;
        end
    end

    // Address stage: one cycle behind the counters.
    always_ff @(posedge pclk) begin
        if (!reset) begin
            h_addr_q <= '0;
            v_addr_q <= '0;
            act_q    <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            fs_q     <= 1'b0;
            ls_q     <= 1'b0;
            cx_q     <= '0;
            col_q    <= '0;
            cy_q     <= '0;
            row_q    <= '0;
        end else begin
            act_q    <= act;
            h_addr_q <= act ? h_cnt_q - H_START : '0;
            v_addr_q <= act ? v_cnt_q - V_START : '0;
            hs_q     <= (h_cnt_q < H_SYNC_E);
            vs_q     <= (v_cnt_q < V_SYNC_E);
            fs_q     <= act && h_first && v_first;
            ls_q     <= act && h_first;
            if (h_act) begin
                if (h_first) begin
                    cx_q  <= '0;
                    col_q <= '0;
                end else if (cx_q == CX_LAST) begin
                    cx_q  <= '0;
                    col_q <= col_q + 7'd1;
                end else begin
                    cx_q  <= cx_q + 4'd1;
                end
            end
            if (v_act && h_first) begin
                if (v_first) begin
                    cy_q  <= '0;
                    row_q <= '0;
                end else if (cy_q == CY_LAST) begin
                    cy_q  <= '0;
                    row_q <= row_q + 5'd1;
                end else begin
                    cy_q  <= cy_q + 4'd1;
                end
            end
        end
    end

`ifdef VGA_CURSOR_EN
    localparam logic [3:0] CY_CURSOR = 4'(CHAR_H - 2);
    assign hit = act_q && (col_q == cursor_col) && (row_q == cursor_row) &&
                 (cy_q >= CY_CURSOR) && frame_cnt_q[4];
`else
    assign hit = 1'b0;
`endif

    // mode_q is stable across every active pixel, so it needs no address-stage copy.
    assign pipe_in = {act_q, hs_q, vs_q, fs_q, ls_q, mode_q, hit};

    vga_delay_line #(
        .WIDTH (PIPE_W),
        .DEPTH (LAT)
    ) u_align (
        .pclk  (pclk),
        .reset (reset),
        .din   (pipe_in),
        .dout  (pipe_out)
    );

    assign {d_act, d_hs, d_vs, d_fs, d_ls, d_mode, d_hit} = pipe_out;

    always_ff @(posedge pclk) begin
        if (!reset) begin
            rgb_q    <= '0;
            valid_q  <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            fstart_q <= 1'b0;
            lstart_q <= 1'b0;
        end else begin
            valid_q  <= d_act;
            hsync_q  <= ~d_hs;
            vsync_q  <= ~d_vs;
            fstart_q <= d_fs;
            lstart_q <= d_ls;
            if (!d_act) begin
                rgb_q <= '0;
            end else if (d_mode) begin
                rgb_q <= (rom_data ^ d_hit) ? fg_color : bg_color;
            end else begin
                rgb_q <= pix_data;
            end
        end
    end

    assign h_addr      = h_addr_q;
    assign v_addr      = v_addr_q;
    assign char_col    = act_q ? col_q : '0;
    assign char_row    = act_q ? row_q : '0;
    assign cell_x      = act_q ? cx_q : '0;
    assign cell_y      = act_q ? cy_q : '0;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign valid       = valid_q;
    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign frame_start = fstart_q;
    assign line_start  = lstart_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_text_timing.sv
// Bench for vga_text_timing: two instances (ROM_LAT 0 and 3) on a small raster,
// checked every cycle against a position-based reference model.
module tb_vga_text_timing;

    localparam int HS = 2, HB = 1, HA = 10, HF = 1;
    localparam int VS = 1, VB = 1, VA = 4, VF = 1;
    localparam int CW = 3, CH = 3;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FRAME = HT * VT;

    logic        pclk = 1'b0;
    logic        reset;
    logic        text_mode;
    logic [23:0] fg_color, bg_color;
    logic        rom_data [2];
    logic [23:0] pix_data [2];

    logic [9:0] h_addr_o [2];
    logic [9:0] v_addr_o [2];
    logic [6:0] char_col_o [2];
    logic [4:0] char_row_o [2];
    logic [3:0] cell_x_o [2];
    logic [3:0] cell_y_o [2];
    logic       hsync_o [2];
    logic       vsync_o [2];
    logic       valid_o [2];
    logic [7:0] r_o [2];
    logic [7:0] g_o [2];
    logic [7:0] b_o [2];
    logic       fs_o [2];
    logic       ls_o [2];
    logic [7:0] fcnt_o [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        vga_text_timing #(
            .H_ACT (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
            .V_ACT (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
            .CHAR_W (CW), .CHAR_H (CH), .ROM_LAT (k * 3)
        ) u_dut (
            .pclk        (pclk),
            .reset       (reset),
            .text_mode   (text_mode),
            .fg_color    (fg_color),
            .bg_color    (bg_color),
            .rom_data    (rom_data[k]),
            .pix_data    (pix_data[k]),
`ifdef VGA_CURSOR_EN
            .cursor_col  (7'h7f),
            .cursor_row  (5'h1f),
`endif
            .h_addr      (h_addr_o[k]),
            .v_addr      (v_addr_o[k]),
            .char_col    (char_col_o[k]),
            .char_row    (char_row_o[k]),
            .cell_x      (cell_x_o[k]),
            .cell_y      (cell_y_o[k]),
            .hsync       (hsync_o[k]),
            .vsync       (vsync_o[k]),
            .valid       (valid_o[k]),
            .vga_r       (r_o[k]),
            .vga_g       (g_o[k]),
            .vga_b       (b_o[k]),
            .frame_start (fs_o[k]),
            .line_start  (ls_o[k]),
            .frame_cnt   (fcnt_o[k])
        );
    end

    always #5 pclk = ~pclk;

    int          checks = 0;
    int          failures = 0;
    int          t;
    int          first_fs [2];
    bit          font [VA][HA];
    logic [23:0] pix_mem [VA][HA];
    bit          mode_of_frame [512];

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s lat=%0d t=%0d got=%0h want=%0h", tag, k * 3, t, obs, exp);
        end
    endtask

    // Raster position p (cycles since release) -> active coordinate.
    function automatic bit pos_xy(input int p, output int x, output int y);
        x = (p % FRAME) % HT - (HS + HB);
        y = (p % FRAME) / HT - (VS + VB);
        return x >= 0 && x < HA && y >= 0 && y < VA;
    endfunction

    task automatic check_cycle(input int k);
        int  x, y, q, h, v;
        bit  a;
        logic [23:0] rgb;
        a = 1'b0;
        x = 0;
        y = 0;
        if (t >= 1) a = pos_xy(t - 1, x, y);
        check("h_addr",   k, 32'(h_addr_o[k]),   a ? x : 0);
        check("v_addr",   k, 32'(v_addr_o[k]),   a ? y : 0);
        check("char_col", k, 32'(char_col_o[k]), a ? x / CW : 0);
        check("cell_x",   k, 32'(cell_x_o[k]),   a ? x % CW : 0);
        check("char_row", k, 32'(char_row_o[k]), a ? y / CH : 0);
        check("cell_y",   k, 32'(cell_y_o[k]),   a ? y % CH : 0);
        check("frame_cnt", k, 32'(fcnt_o[k]),    (t / FRAME) % 256);

        q = t - 3 * k - 2;
        if (q < 0) begin
            check("hsync", k, 32'(hsync_o[k]), 1);
            check("vsync", k, 32'(vsync_o[k]), 1);
            check("valid", k, 32'(valid_o[k]), 0);
            check("frame_start", k, 32'(fs_o[k]), 0);
            check("line_start", k, 32'(ls_o[k]), 0);
            check("rgb", k, 32'({r_o[k], g_o[k], b_o[k]}), 0);
        end else begin
            h = (q % FRAME) % HT;
            v = (q % FRAME) / HT;
            a = pos_xy(q, x, y);
            rgb = 24'h0;
            if (a) begin
                if (mode_of_frame[q / FRAME]) rgb = font[y][x] ? fg_color : bg_color;
                else rgb = pix_mem[y][x];
            end
            check("hsync", k, 32'(hsync_o[k]), (h >= HS) ? 1 : 0);
            check("vsync", k, 32'(vsync_o[k]), (v >= VS) ? 1 : 0);
            check("valid", k, 32'(valid_o[k]), a ? 1 : 0);
            check("frame_start", k, 32'(fs_o[k]), (a && x == 0 && y == 0) ? 1 : 0);
            check("line_start", k, 32'(ls_o[k]), (a && x == 0) ? 1 : 0);
            check("rgb", k, 32'({r_o[k], g_o[k], b_o[k]}), 32'(rgb));
        end
        if (fs_o[k] === 1'b1 && first_fs[k] < 0) first_fs[k] = t;
    endtask

    // Inputs for cycle t; the memory returns data for the position addressed ROM_LAT earlier.
    task automatic drive();
        text_mode = 1'($urandom_range(0, 1));
        fg_color  = 24'($urandom);
        bg_color  = 24'($urandom);
        if (t % FRAME == 0) mode_of_frame[t / FRAME] = text_mode;
        for (int k = 0; k < 2; k++) begin
            int r, x, y;
            r = t - 1 - 3 * k;
            rom_data[k] = 1'($urandom_range(0, 1));
            pix_data[k] = 24'($urandom);
            if (r >= 0 && pos_xy(r, x, y)) begin
                rom_data[k] = font[y][x];
                pix_data[k] = pix_mem[y][x];
            end
        end
    endtask

    task automatic step(input bit assert_rst);
        for (int k = 0; k < 2; k++) check_cycle(k);
        drive();
        reset = !assert_rst;
        @(negedge pclk);
        if (assert_rst) begin
            reset = 1'b1;
            t = 0;
            first_fs = '{-1, -1};
        end else begin
            t++;
        end
    endtask

    task automatic check_first_fs();
        for (int k = 0; k < 2; k++)
            check("first_frame_start", k, 32'(first_fs[k]), HT * (VS + VB) + HS + HB + 3 * k + 2);
    endtask

    initial begin
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++) begin
                font[y][x]    = 1'($urandom_range(0, 1));
                pix_mem[y][x] = 24'($urandom);
            end
        reset       = 1'b0;
        text_mode   = 1'b1;
        fg_color    = '0;
        bg_color    = '0;
        rom_data    = '{1'b0, 1'b0};
        pix_data    = '{24'h0, 24'h0};
        repeat (3) @(negedge pclk);
        reset    = 1'b1;
        t        = 0;
        first_fs = '{-1, -1};

        // Run into an active line of the fourth frame, then reset mid-picture.
        repeat (3 * FRAME + 5 * HT + 6) step(1'b0);
        check_first_fs();
        step(1'b1);

        // Long enough for frame_cnt to wrap 255 -> 0.
        repeat (258 * FRAME) step(1'b0);
        check_first_fs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_text_timing.md
# vga_text_timing

Parametrised VGA raster generator for the NPC display path; successor to the fixed 640x480 controller. Produces programmable H/V sync and blanking, pixel and character-cell addresses for the font/screen RAM, and a latency-matched, registered RGB output. Adds text/graphics mode select, foreground/background colours, frame counter and frame/line strobes. It sits between the VGA pixel clock domain's memories and the board DAC.

## Interface
- H_ACT, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width (pixels)
- V_ACT, 480, active lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width (lines)
- CHAR_W / CHAR_H, 9 / 16, character cell size in pixels
- ROM_LAT, 1, read latency (cycles, 0..3) of the font/pixel memory
- pclk  in  1  pixel clock, the only clock
- reset  in  1  synchronous, active-low (0 = reset)
- text_mode  in  1  1 = text (rom_data), 0 = graphics (pix_data); sampled at frame start
- fg_color / bg_color  in  24  text colours {R,G,B}
- rom_data  in  1  font pixel, valid ROM_LAT cycles after address outputs
- pix_data  in  24  graphics pixel, same latency as rom_data
- h_addr / v_addr  out  10  active pixel coordinate, 0 when blanked
- char_col  out  7  cell column; char_row  out  5  cell row; 0 when blanked
- cell_x  out  4  pixel within cell (0..CHAR_W-1); cell_y  out  4  line within cell
- hsync / vsync  out  1  active-low sync
- valid  out  1  active video, aligned to RGB
- vga_r / vga_g / vga_b  out  8  colour, 0 when !valid
- frame_start / line_start  out  1  one-cycle strobes, aligned to RGB
- frame_cnt  out  8  completed frames, wraps 255->0

## Operation
- h_cnt 0..H_TOTAL-1 (H_TOTAL=H_SYNC+H_BP+H_ACT+H_FP); v_cnt 0..V_TOTAL-1, advances when h_cnt wraps; both wrap to 0 at last line/pixel together.
- Line order: sync, back porch, active, front porch. hsync=0 while h_cnt<H_SYNC; active while H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACT; vertical identical.
- cell_x/char_col from incrementing counters (no divider): cell_x cleared at first active pixel, wraps at CHAR_W-1 and increments char_col. cell_y/char_row likewise per active line, cleared at first active line. Partial last column (640/9 -> col 71, cell_x 0..0) is emitted as-is.
- Text: colour = rom_data ? fg_color : bg_color. Graphics: colour = pix_data.
- Mode latched when v_cnt=0 and h_cnt=0; mid-frame changes ignored.
- frame_cnt increments at the v/h wrap.
- Reset mid-frame: all counters, pipeline and latched mode (text) return to reset state next edge; no partial strobes.

## Timing
- Counters, address outputs and pipeline registered; no combinational input-to-output path.
- Addresses lag counters by 1 cycle. RGB, valid, hsync, vsync, strobes lag addresses by ROM_LAT+1 cycles, so all pixel-level outputs for one raster position appear on the same cycle.
- Reset values: hsync=1, vsync=1, valid=0, RGB=0, strobes=0, frame_cnt=0, all addresses 0, mode=text. First cycle after release counters=0 (in sync region).
- frame_start: first active pixel of line 0 of active area; line_start: first active pixel of each active line.

## Configuration
- VGA_CURSOR_EN defined: extra inputs cursor_col[6:0], cursor_row[4:0]; in text mode, cell matching the cursor with cell_y >= CHAR_H-2 shows fg/bg swapped while frame_cnt[4]=1 (blink every 16 frames). Cursor compare pipelined with same latency.
- Undefined: ports absent, no cursor logic; output identical to cursor never matching.

## Structure
- Package vga_pkg: default 640x480@60 timing constants, colour width, RGB struct typedef, ROM_LAT limit.
- Sub-module vga_delay_line (parameter WIDTH, DEPTH incl. 0) used to align sync/valid/strobes/mode/cursor hit to the ROM latency.

## Test plan
- Reset then free-run one frame, defaults -> hsync low exactly 96 of every 800 cycles, vsync low 2 lines of 525, 640x480=307200 valid cycles.
- Text, fg=FF0000, bg=0000FF, rom_data=h_addr[0] -> at valid pixel x=0 RGB=0000FF, x=1 FF0000, blanked RGB=0.
- Check cell counters -> at h_addr=17 char_col=1 cell_x=8; h_addr=18 char_col=2 cell_x=0; v_addr=479 char_row=29 cell_y=15.
- ROM_LAT=0 and 3 -> RGB for h_addr=N appears with valid exactly ROM_LAT+1 cycles after address N; frame_start coincides with h_addr=0,v_addr=0 pixel.
- Toggle text_mode mid-frame -> output mode changes only at next frame; frame_cnt 255 -> 0 after 256 frames.
- Assert reset at line 200 -> next cycle outputs at reset values; after release first frame_start after exactly H_TOTAL*(V_SYNC+V_BP)+H_SYNC+H_BP+ROM_LAT+2 cycles.
